// File: rtl/shift_pipe_pkg.sv
// Shared types and the combinational shift used by shift_pipe.
// The shift works on a MAX_W-wide container; callers pass their real width.
package shift_pipe_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } shift_mode_e;

    function automatic logic [MAX_W-1:0] shift_word(
        input logic [MAX_W-1:0] data,
        input int unsigned      w,
        input int unsigned      sh,
        input shift_mode_e      mode
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] d;
        logic [MAX_W-1:0] res;
        int unsigned      rot;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        d    = data & mask;
        rot  = sh % w;
        case (mode)
            SLL:     res = (d << sh) & mask;
            SRL:     res = d >> sh;
            // Fill the vacated top bits with the sign bit of the w-bit word.
            SRA:     res = (d >> sh) | (d[w-1] ? (mask & ~(mask >> sh)) : '0);
            ROL:     res = ((d << rot) | (d >> (w - rot))) & mask;
            default: res = d;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One valid/ready register slice; accepts when empty or when its output is taken.
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstf,
    input  logic [W-1:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    input  logic         dn_ready
);

    logic [W-1:0] data_p0;
    logic         vld_p0;

    assign up_ready = !vld_p0 || dn_ready;
    assign dn_data  = data_p0;
    assign dn_valid = vld_p0;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (up_valid && up_ready) begin
            vld_p0  <= 1'b1;
            data_p0 <= up_data;
        end else if (dn_ready) begin
            vld_p0  <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready handshakes,
// an optional input skid buffer, and a registered occupancy count.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  STAGES    = 2,
    parameter int  REG_READY = 0,
    localparam int SH_W      = $clog2(DATA_W),
    localparam int CNT_W     = $clog2(STAGES + 2)
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [DATA_W-1:0] t0_data,
    input  logic [SH_W-1:0]   t0_shamt,
    input  logic [1:0]        t0_mode,
    input  logic              t0_valid,
    output logic              t0_ready,
    output logic [DATA_W-1:0] i0_data,
    output logic              i0_valid,
    input  logic              i0_ready,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] pipe_data [STAGES+1];
    logic              pipe_vld  [STAGES+1];
    logic              pipe_rdy  [STAGES+1];
    logic              accept;
    logic              pop;

    assign shifted = DATA_W'(shift_word(MAX_W'(t0_data), DATA_W, 32'(t0_shamt),
                                        shift_mode_e'(t0_mode)));

    generate
        if (REG_READY != 0) begin : g_skid
            logic              skid_vld;
            logic [DATA_W-1:0] skid_data;

            // A held entry always goes to stage 0 before any new input is taken.
            assign t0_ready     = !skid_vld;
            assign pipe_vld[0]  = skid_vld || t0_valid;
            assign pipe_data[0] = skid_vld ? skid_data : shifted;

            always_ff @(posedge clk or negedge rstf) begin
                if (!rstf) begin
                    skid_vld  <= 1'b0;
                    skid_data <= '0;
                end else if (skid_vld) begin
                    if (pipe_rdy[0]) skid_vld <= 1'b0;
                end else if (t0_valid && !pipe_rdy[0]) begin
                    skid_vld  <= 1'b1;
                    skid_data <= shifted;
                end
            end
        end else begin : g_direct
            assign t0_ready     = pipe_rdy[0];
            assign pipe_vld[0]  = t0_valid;
            assign pipe_data[0] = shifted;
        end

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            shift_pipe_stage #(.W(DATA_W)) u_stage (
                .clk      (clk),
                .rstf     (rstf),
                .up_data  (pipe_data[k]),
                .up_valid (pipe_vld[k]),
                .up_ready (pipe_rdy[k]),
                .dn_data  (pipe_data[k+1]),
                .dn_valid (pipe_vld[k+1]),
                .dn_ready (pipe_rdy[k+1])
            );
        end
    endgenerate

    assign pipe_rdy[STAGES] = i0_ready;
    assign i0_data          = pipe_data[STAGES];
    assign i0_valid         = pipe_vld[STAGES];

    assign accept = t0_valid && t0_ready;
    assign pop    = i0_valid && i0_ready;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            occupancy <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Drives a REG_READY=0 and a REG_READY=1 shift_pipe from shared inputs and
// checks each against its own FIFO-of-expected-results model.
module tb_shift_pipe;

    localparam int DATA_W = 32;
    localparam int STAGES = 2;
    localparam int DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        rstf;
    logic [31:0] t0_data;
    logic [4:0]  t0_shamt;
    logic [1:0]  t0_mode;
    logic        t0_valid;
    logic        i0_ready;

    logic        t0_ready_a [2];
    logic [31:0] i0_data_a  [2];
    logic        i0_valid_a [2];
    logic [1:0]  occ_a      [2];

    logic [31:0] mem [2][DEPTH];
    int          wp   [2];
    int          rp   [2];
    int          nacc [2];
    int          npop [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    shift_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .REG_READY(0)) dut0 (
        .clk(clk), .rstf(rstf), .t0_data(t0_data), .t0_shamt(t0_shamt),
        .t0_mode(t0_mode), .t0_valid(t0_valid), .t0_ready(t0_ready_a[0]),
        .i0_data(i0_data_a[0]), .i0_valid(i0_valid_a[0]), .i0_ready(i0_ready),
        .occupancy(occ_a[0])
    );

    shift_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .REG_READY(1)) dut1 (
        .clk(clk), .rstf(rstf), .t0_data(t0_data), .t0_shamt(t0_shamt),
        .t0_mode(t0_mode), .t0_valid(t0_valid), .t0_ready(t0_ready_a[1]),
        .i0_data(i0_data_a[1]), .i0_valid(i0_valid_a[1]), .i0_ready(i0_ready),
        .occupancy(occ_a[1])
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input int m);
        logic [63:0] dd;
        case (m)
            0:       return d << s;
            1:       return d >> s;
            2:       return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} << (s % 32);
                return dd[63:32];
            end
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    // Model: every accepted transaction's expected result is queued; outputs pop in order.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstf) begin
                wp[k] = 0;
                rp[k] = 0;
                chk("rst_i0_valid", k, 64'(i0_valid_a[k]), 64'd0);
                chk("rst_occupancy", k, 64'(occ_a[k]), 64'd0);
            end else begin
                chk("occupancy", k, 64'(occ_a[k]), 64'(wp[k] - rp[k]));
                chk("occupancy_max", k, 64'(int'(occ_a[k]) <= STAGES + k), 64'd1);
                if (i0_valid_a[k]) begin
                    if (wp[k] != rp[k])
                        chk("i0_data", k, 64'(i0_data_a[k]), 64'(mem[k][rp[k] % DEPTH]));
                    else
                        chk("entries_behind_i0_valid", k, 64'(wp[k] - rp[k]), 64'd1);
                    if (i0_ready) begin
                        rp[k]++;
                        npop[k]++;
                    end
                end
                if (t0_valid && t0_ready_a[k]) begin
                    mem[k][wp[k] % DEPTH] = ref_shift(t0_data, int'(t0_shamt), int'(t0_mode));
                    wp[k]++;
                    nacc[k]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_input();
        t0_data  = $urandom;
        t0_shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        t0_mode  = 2'($urandom);
    endtask

    // One transaction into an empty pipe; checks latency, result and occupancy 1,1,0.
    task automatic single(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                          input logic [31:0] exp, input string tag);
        t0_data  = d;
        t0_shamt = s;
        t0_mode  = m;
        t0_valid = 1'b1;
        i0_ready = 1'b1;
        step();
        t0_valid = 1'b0;
        t0_data  = $urandom;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_occ1"}, k, 64'(occ_a[k]), 64'd1);
            chk({tag, "_early_valid"}, k, 64'(i0_valid_a[k]), 64'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_occ2"}, k, 64'(occ_a[k]), 64'd1);
            chk({tag, "_valid"}, k, 64'(i0_valid_a[k]), 64'd1);
            chk({tag, "_data"}, k, 64'(i0_data_a[k]), 64'(exp));
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_occ3"}, k, 64'(occ_a[k]), 64'd0);
            chk({tag, "_drained"}, k, 64'(i0_valid_a[k]), 64'd0);
        end
        step();
    endtask

    int          acc_base [2];
    int          pop_base [2];
    logic [31:0] held     [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            wp[k] = 0; rp[k] = 0; nacc[k] = 0; npop[k] = 0;
        end
        rstf     = 1'b0;
        t0_valid = 1'b0;
        i0_ready = 1'b0;
        t0_data  = '0;
        t0_shamt = '0;
        t0_mode  = '0;

        repeat (3) @(negedge clk);
        step();
        rstf = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("ready_after_reset", k, 64'(t0_ready_a[k]), 64'd1);
        step();

        single(32'h0000_0001, 5'd2,  2'd0, 32'h0000_0004, "sll2");
        single(32'h8000_0000, 5'd4,  2'd1, 32'h0800_0000, "srl4");
        single(32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000, "sra4");
        single(32'h8000_0000, 5'd4,  2'd3, 32'h0000_0008, "rol4");
        single(32'h8000_0001, 5'd0,  2'd2, 32'h8000_0001, "sra0");
        single(32'hA5A5_0F0F, 5'd0,  2'd3, 32'hA5A5_0F0F, "rol0");
        single(32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF, "sra31");
        single(32'h0000_0003, 5'd31, 2'd0, 32'h8000_0000, "sll31");

        // Full-rate stream.
        i0_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin acc_base[k] = nacc[k]; pop_base[k] = npop[k]; end
        for (int i = 0; i < 100; i++) begin
            t0_valid = 1'b1;
            rand_input();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("stream_ready", k, 64'(t0_ready_a[k]), 64'd1);
                if (i >= STAGES) chk("stream_out_valid", k, 64'(i0_valid_a[k]), 64'd1);
            end
            step();
        end
        t0_valid = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            chk("stream_accepted", k, 64'(nacc[k] - acc_base[k]), 64'd100);
            chk("stream_popped", k, 64'(npop[k] - pop_base[k]), 64'd100);
        end

        // Backpressure: offer inputs with the output stalled.
        i0_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin acc_base[k] = nacc[k]; pop_base[k] = npop[k]; end
        for (int i = 0; i < 5; i++) begin
            t0_valid = 1'b1;
            rand_input();
            step();
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("stall_ready_low", k, 64'(t0_ready_a[k]), 64'd0);
            held[k] = i0_data_a[k];
        end
        repeat (3) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("stall_data_stable", k, 64'(i0_data_a[k]), 64'(held[k]));
            chk("stall_valid_held", k, 64'(i0_valid_a[k]), 64'd1);
        end
        step();
        for (int k = 0; k < 2; k++)
            chk("stall_accept_count", k, 64'(nacc[k] - acc_base[k]), 64'(STAGES + k));
        t0_valid = 1'b0;
        i0_ready = 1'b1;
        repeat (6) step();
        for (int k = 0; k < 2; k++) begin
            chk("stall_drain_occ", k, 64'(occ_a[k]), 64'd0);
            chk("stall_drain_count", k, 64'(npop[k] - pop_base[k]), 64'(STAGES + k));
        end

        // Random valid/ready at 50%.
        for (int i = 0; i < 400; i++) begin
            t0_valid = 1'($urandom);
            i0_ready = 1'($urandom);
            rand_input();
            step();
        end
        t0_valid = 1'b0;
        i0_ready = 1'b1;
        repeat (6) step();
        for (int k = 0; k < 2; k++) begin
            chk("random_drain_occ", k, 64'(occ_a[k]), 64'd0);
            chk("random_no_loss", k, 64'(npop[k]), 64'(nacc[k]));
        end

        // Asynchronous reset with the pipe full.
        i0_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t0_valid = 1'b1;
            rand_input();
            step();
        end
        for (int k = 0; k < 2; k++) chk("pre_reset_occ", k, 64'(occ_a[k]), 64'(STAGES + k));
        #2;
        rstf = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_valid", k, 64'(i0_valid_a[k]), 64'd0);
            chk("async_rst_occ", k, 64'(occ_a[k]), 64'd0);
        end
        t0_valid = 1'b0;
        @(negedge clk);
        step();
        rstf = 1'b1;
        single(32'h1234_5678, 5'd8, 2'd3, 32'h3456_7812, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
